paddle_motion_ctrl: RTL and testbench

Parametrised next-generation paddle position controller for the Pong datapath. It converts left/right button levels into a paddle x-coordinate, with a hold-to-accelerate speed profile, saturating clamps at configurable screen limits, and a synchronous recentre. It is clocked by the paddle tick clock and feeds paddle_x to the renderer and the ball-collision logic.

---
 rtl/paddle_motion_ctrl.sv | 162 ++++++++++++++++
 tb/tb_paddle_motion_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/paddle_motion_ctrl.sv
// Paddle position controller: converts left/right button levels into a
// paddle x-coordinate with a hold-to-accelerate speed profile, saturating
// clamps at the screen limits and a synchronous recentre.
module paddle_motion_ctrl #(
    parameter int X_W         = 10,
    parameter int MIN_X       = 5,
    parameter int MAX_X       = 555,
    parameter int START_X     = 280,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 8,
    parameter int SPEED_W     = 3
) (
    input  logic               Paddle_Clock,
    input  logic               Reset_n,
    input  logic               step_en,
    input  logic               moving_right,
    input  logic               moving_left,
    input  logic               recentre,
    output logic [X_W-1:0]     paddle_x,
    output logic [SPEED_W-1:0] speed,
    output logic [1:0]         dir,
    output logic               at_left,
    output logic               at_right
);

    localparam int HC_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

    localparam logic [X_W-1:0]     START_XV = X_W'(START_X);
    localparam logic [X_W-1:0]     MIN_XV   = X_W'(MIN_X);
    localparam logic [X_W-1:0]     MAX_XV   = X_W'(MAX_X);
    localparam logic [X_W:0]       MIN_XE   = (X_W+1)'(MIN_X);
    localparam logic [X_W:0]       MAX_XE   = (X_W+1)'(MAX_X);
    localparam logic [SPEED_W-1:0] MAX_SPD  = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] SPD_ONE  = SPEED_W'(1);
    localparam logic [SPEED_W-1:0] SPD_ZERO = SPEED_W'(0);
    localparam logic [HC_W-1:0]    HC_LAST  = HC_W'(ACCEL_TICKS - 1);
    localparam logic [HC_W-1:0]    HC_ZERO  = HC_W'(0);
    localparam logic [HC_W-1:0]    HC_ONE   = HC_W'(1);

    // The state encoding doubles as the dir output.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MOVE_R = 2'b01,
        ST_MOVE_L = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [HC_W-1:0]    hold_q, hold_d;

    logic               cmd_r_s;
    logic               cmd_l_s;
    state_e             want_s;
    logic [SPEED_W-1:0] spd_s;
    logic [HC_W-1:0]    hold_s;
    logic [X_W:0]       x_ext_s;
    logic [X_W:0]       sum_r_s;
    logic [X_W:0]       lim_l_s;

    // Pressing both buttons cancels out, same as pressing neither.
    assign cmd_r_s = moving_right & ~moving_left;
    assign cmd_l_s = moving_left & ~moving_right;

    // Next-state, speed profile and clamped position arithmetic.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        speed_d = speed_q;
        hold_d  = hold_q;
        want_s  = ST_IDLE;
        spd_s   = speed_q;
        hold_s  = hold_q;
        x_ext_s = {1'b0, x_q};
        sum_r_s = {1'b0, x_q};
        lim_l_s = MIN_XE;

        if (recentre) begin
            state_d = ST_IDLE;
            x_d     = START_XV;
            speed_d = SPD_ZERO;
            hold_d  = HC_ZERO;
        end else if (!step_en) begin
            state_d = state_q;
        end else if (!cmd_r_s && !cmd_l_s) begin
            state_d = ST_IDLE;
            speed_d = SPD_ZERO;
            hold_d  = HC_ZERO;
        end else begin
            if (cmd_r_s) begin
                want_s = ST_MOVE_R;
            end else begin
                want_s = ST_MOVE_L;
            end

            // Continuing in the same direction accelerates; a start or a
            // reversal restarts the profile at one pixel per step.
            if (state_q == want_s) begin
                if ((hold_q == HC_LAST) && (speed_q < MAX_SPD)) begin
                    spd_s  = speed_q + SPD_ONE;
                    hold_s = HC_ZERO;
                end else if (speed_q == MAX_SPD) begin
                    spd_s  = speed_q;
                    hold_s = HC_ZERO;
                end else begin
                    spd_s  = speed_q;
                    hold_s = hold_q + HC_ONE;
                end
            end else begin
                spd_s  = SPD_ONE;
                hold_s = HC_ZERO;
            end

            // One extra bit of headroom so neither direction can wrap.
            sum_r_s = x_ext_s + (X_W+1)'(spd_s);
            lim_l_s = MIN_XE + (X_W+1)'(spd_s);
            state_d = want_s;
            speed_d = spd_s;
            hold_d  = hold_s;

            if (want_s == ST_MOVE_R) begin
                if (sum_r_s > MAX_XE) begin
                    x_d     = MAX_XV;
                    speed_d = SPD_ONE;
                    hold_d  = HC_ZERO;
                end else begin
                    x_d = sum_r_s[X_W-1:0];
                end
            end else begin
                if (x_ext_s < lim_l_s) begin
                    x_d     = MIN_XV;
                    speed_d = SPD_ONE;
                    hold_d  = HC_ZERO;
                end else begin
                    x_d = x_q - X_W'(spd_s);
                end
            end
        end
    end

    // State, position, speed and hold-counter registers.
    always_ff @(posedge Paddle_Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            x_q     <= START_XV;
            speed_q <= SPD_ZERO;
            hold_q  <= HC_ZERO;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            speed_q <= speed_d;
            hold_q  <= hold_d;
        end
    end

    assign paddle_x = x_q;
    assign speed    = speed_q;
    assign dir      = state_q;
    assign at_left  = (x_q == MIN_XV);
    assign at_right = (x_q == MAX_XV);

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Self-checking bench for paddle_motion_ctrl: directed scenarios plus
// randomized button/step/recentre sequences against an integer model.
module tb_paddle_motion_ctrl;

    localparam int X_W         = 10;
    localparam int MIN_X       = 5;
    localparam int MAX_X       = 555;
    localparam int START_X     = 280;
    localparam int MAX_SPEED   = 4;
    localparam int ACCEL_TICKS = 8;
    localparam int SPEED_W     = 3;

    logic               clk;
    logic               rst_n;
    logic               step_en;
    logic               mv_r;
    logic               mv_l;
    logic               recentre;
    logic [X_W-1:0]     paddle_x;
    logic [SPEED_W-1:0] speed;
    logic [1:0]         dir;
    logic               at_left;
    logic               at_right;

    int n_vec;
    int n_err;

    // Reference model: plain signed integers, direction 0 idle / 1 right / 2 left.
    int m_x;
    int m_spd;
    int m_dir;
    int m_hold;

    paddle_motion_ctrl #(
        .X_W(X_W), .MIN_X(MIN_X), .MAX_X(MAX_X), .START_X(START_X),
        .MAX_SPEED(MAX_SPEED), .ACCEL_TICKS(ACCEL_TICKS), .SPEED_W(SPEED_W)
    ) dut (
        .Paddle_Clock (clk),
        .Reset_n      (rst_n),
        .step_en      (step_en),
        .moving_right (mv_r),
        .moving_left  (mv_l),
        .recentre     (recentre),
        .paddle_x     (paddle_x),
        .speed        (speed),
        .dir          (dir),
        .at_left      (at_left),
        .at_right     (at_right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_x    = START_X;
        m_spd  = 0;
        m_dir  = 0;
        m_hold = 0;
    endtask

    task automatic m_step(input bit r, input bit l, input bit en, input bit rc);
        int cmd;
        int target;
        if (rc) begin
            m_reset();
        end else if (en) begin
            cmd = (r && !l) ? 1 : ((l && !r) ? 2 : 0);
            if (cmd == 0) begin
                m_dir  = 0;
                m_spd  = 0;
                m_hold = 0;
            end else begin
                if (cmd != m_dir) begin
                    m_dir  = cmd;
                    m_spd  = 1;
                    m_hold = 0;
                end else if (m_hold == ACCEL_TICKS - 1 && m_spd < MAX_SPEED) begin
                    m_spd  = m_spd + 1;
                    m_hold = 0;
                end else if (m_spd == MAX_SPEED) begin
                    m_hold = 0;
                end else begin
                    m_hold = m_hold + 1;
                end
                target = (m_dir == 1) ? m_x + m_spd : m_x - m_spd;
                if (target > MAX_X || target < MIN_X) begin
                    m_x    = (target > MAX_X) ? MAX_X : MIN_X;
                    m_spd  = 1;
                    m_hold = 0;
                end else begin
                    m_x = target;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x"},     int'(paddle_x), m_x);
        chk({tag, ".speed"}, int'(speed),    m_spd);
        chk({tag, ".dir"},   int'(dir),      m_dir);
        chk({tag, ".atl"},   int'(at_left),  (m_x == MIN_X) ? 1 : 0);
        chk({tag, ".atr"},   int'(at_right), (m_x == MAX_X) ? 1 : 0);
    endtask

    // Apply one set of inputs across one rising edge, then compare to the model.
    task automatic step(input string tag, input bit r, input bit l, input bit en, input bit rc);
        mv_r     = r;
        mv_l     = l;
        step_en  = en;
        recentre = rc;
        @(posedge clk);
        m_step(r, l, en, rc);
        #1;
        check_all(tag);
    endtask

    initial begin
        int mode;
        int frz_x;
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        step_en  = 1'b0;
        mv_r     = 1'b0;
        mv_l     = 1'b0;
        recentre = 1'b0;
        m_reset();

        // Reset state, then idle steps.
        #12;
        check_all("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step("idle", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("idle_x", int'(paddle_x), 280);
        chk("idle_dir", int'(dir), 0);

        // Acceleration profile holding right.
        for (int i = 1; i <= 25; i++) begin
            step("accel", 1'b1, 1'b0, 1'b1, 1'b0);
            if (i == 1)  chk("acc1_x", int'(paddle_x), 281);
            if (i == 8)  chk("acc8_x", int'(paddle_x), 288);
            if (i == 9)  begin chk("acc9_x", int'(paddle_x), 290); chk("acc9_spd", int'(speed), 2); end
            if (i == 24) begin chk("acc24_x", int'(paddle_x), 328); chk("acc24_spd", int'(speed), 3); end
            if (i == 25) begin chk("acc25_x", int'(paddle_x), 332); chk("acc25_spd", int'(speed), 4); end
        end

        // Drive into the right wall, then the left wall.
        for (int i = 0; i < 200; i++) step("wall_r", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("wall_r_x", int'(paddle_x), 555);
        chk("wall_r_at", int'(at_right), 1);
        chk("wall_r_spd", int'(speed), 1);
        for (int i = 0; i < 300; i++) step("wall_l", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("wall_l_x", int'(paddle_x), 5);
        chk("wall_l_at", int'(at_left), 1);
        chk("wall_l_spd", int'(speed), 1);

        // Reversal at speed 3, then both buttons.
        step("rc", 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) step("rev_pre", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rev_pre_spd", int'(speed), 3);
        frz_x = int'(paddle_x);
        step("rev", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rev_dir", int'(dir), 2);
        chk("rev_spd", int'(speed), 1);
        chk("rev_x", int'(paddle_x), frz_x - 1);
        step("both", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("both_dir", int'(dir), 0);
        chk("both_x", int'(paddle_x), frz_x - 1);

        // Freeze with step_en low mid-move, then recentre while frozen.
        for (int i = 0; i < 12; i++) step("pre_frz", 1'b1, 1'b0, 1'b1, 1'b0);
        frz_x = int'(paddle_x);
        for (int i = 0; i < 5; i++) step("frz", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("frz_x", int'(paddle_x), frz_x);
        step("rc_frz", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rc_frz_x", int'(paddle_x), 280);
        chk("rc_frz_dir", int'(dir), 0);

        // Asynchronous reset mid-move at x=400, speed=4.
        step("rc2", 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 42; i++) step("to400", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("at400_x", int'(paddle_x), 400);
        chk("at400_spd", int'(speed), 4);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all("async_rst");
        #1;
        rst_n = 1'b1;

        // Randomized sequences with persistent button intent.
        mode = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 6) mode = $urandom_range(0, 3);
            step("rand", mode[0], mode[1], ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
